// File: rtl/sweep_response_collector.sv
// sweep_response_collector: walks every stimulus code of a combinational
// block under test, waits a programmable settle time per code, and folds
// each sampled response into a rotate-XOR signature, a non-zero count and
// a running maximum (with the code that produced it).
module sweep_response_collector #(
  parameter int IN_W   = 4,
  parameter int OUT_W  = 24,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] signature,
  output logic [IN_W:0]    nonzero_count,
  output logic [OUT_W-1:0] max_value,
  output logic [IN_W-1:0]  max_code
);

  // Settle counter only has to reach SETTLE-1; keep at least one bit.
  localparam int             CW        = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]  CNT_LAST  = CW'(SETTLE - 1);
  localparam logic [IN_W-1:0] CODE_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [IN_W-1:0]  code_q,  code_d;
  logic [OUT_W-1:0] sig_q,   sig_d;
  logic [IN_W:0]    nz_q,    nz_d;
  logic [OUT_W-1:0] max_q,   max_d;
  logic [IN_W-1:0]  mcode_q, mcode_d;

  logic settled;
  logic last_code;
  logic resp_nz;

  assign settled   = (cnt_q == CNT_LAST);
  assign last_code = (code_q == CODE_LAST);
  assign resp_nz   = (dut_out != '0);

  // State register; reset drops straight back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: WAIT for SETTLE cycles, one CAPTURE per code, DONE once.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_WAIT;
      S_WAIT:    if (settled) state_d = S_CAPTURE;
      S_CAPTURE: state_d = last_code ? S_DONE : S_WAIT;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from state; DONE is a single-cycle pulse.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_WAIT, S_CAPTURE: busy = 1'b1;
      S_DONE:            done = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state: clear on accepted start, count in WAIT, fold in CAPTURE.
  always_comb begin
    cnt_d   = cnt_q;
    code_d  = code_q;
    sig_d   = sig_q;
    nz_d    = nz_q;
    max_d   = max_q;
    mcode_d = mcode_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d   = '0;
          code_d  = '0;
          sig_d   = '0;
          nz_d    = '0;
          max_d   = '0;
          mcode_d = '0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
      end
      S_CAPTURE: begin
        // Rotate left by one (MSB wraps to bit 0), then absorb the response.
        sig_d = {sig_q[OUT_W-2:0], sig_q[OUT_W-1]} ^ dut_out;
        nz_d  = nz_q + (IN_W+1)'(resp_nz);
        // Strict compare so the earliest code keeps a tied maximum.
        if (dut_out > max_q) begin
          max_d   = dut_out;
          mcode_d = code_q;
        end
        // Stimulus stops at all-ones instead of wrapping back to zero.
        if (!last_code) begin
          code_d = code_q + IN_W'(1);
          cnt_d  = '0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; results persist in IDLE until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      code_q  <= '0;
      sig_q   <= '0;
      nz_q    <= '0;
      max_q   <= '0;
      mcode_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      sig_q   <= sig_d;
      nz_q    <= nz_d;
      max_q   <= max_d;
      mcode_q <= mcode_d;
    end
  end

  assign dut_in        = code_q;
  assign signature     = sig_q;
  assign nonzero_count = nz_q;
  assign max_value     = max_q;
  assign max_code      = mcode_q;

endmodule

// File: tb/tb_sweep_response_collector.sv
// Bench for sweep_response_collector: two instances (SETTLE=1 and SETTLE=3)
// share start/reset and a response lookup table; a sweep-level model predicts
// every output on every cycle from the table.
module tb_sweep_response_collector;

  localparam int IN_W  = 4;
  localparam int OUT_W = 24;
  localparam int NC    = 16;

  logic clk = 1'b0;
  logic rst;
  logic start;
  always #5 clk = ~clk;

  logic [OUT_W-1:0] lut [NC];

  logic [IN_W-1:0]  din  [2];
  logic [OUT_W-1:0] dout [2];
  logic             busy [2];
  logic             done [2];
  logic [OUT_W-1:0] sig  [2];
  logic [IN_W:0]    nz   [2];
  logic [OUT_W-1:0] mx   [2];
  logic [IN_W-1:0]  mc   [2];

  assign dout[0] = lut[din[0]];
  assign dout[1] = lut[din[1]];

  sweep_response_collector #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(1)) u_a (
    .clk(clk), .rst(rst), .start(start), .dut_in(din[0]), .dut_out(dout[0]),
    .busy(busy[0]), .done(done[0]), .signature(sig[0]), .nonzero_count(nz[0]),
    .max_value(mx[0]), .max_code(mc[0]));

  sweep_response_collector #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(3)) u_b (
    .clk(clk), .rst(rst), .start(start), .dut_in(din[1]), .dut_out(dout[1]),
    .busy(busy[1]), .done(done[1]), .signature(sig[1]), .nonzero_count(nz[1]),
    .max_value(mx[1]), .max_code(mc[1]));

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int settle_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // ---------------- model ----------------
  // Prefix results after m codes have been folded in (m = 0..16).
  logic [31:0] psig [2][NC+1];
  logic [31:0] pcnt [2][NC+1];
  logic [31:0] pmax [2][NC+1];
  logic [31:0] pcod [2][NC+1];
  bit          insw [2];
  int          ncyc [2];
  logic [31:0] h_sig [2], h_cnt [2], h_max [2], h_cod [2], h_din [2];

  task automatic build(input int i);
    logic [31:0] s, c, m, mcd;
    s = 0; c = 0; m = 0; mcd = 0;
    psig[i][0] = 0; pcnt[i][0] = 0; pmax[i][0] = 0; pcod[i][0] = 0;
    for (int k = 0; k < NC; k++) begin
      s = (((s << 1) | (s >> (OUT_W - 1))) & 32'h00FF_FFFF) ^ 32'(lut[k]);
      if (lut[k] != 0) c = c + 1;
      if (32'(lut[k]) > m) begin m = 32'(lut[k]); mcd = k; end
      psig[i][k+1] = s; pcnt[i][k+1] = c; pmax[i][k+1] = m; pcod[i][k+1] = mcd;
    end
  endtask

  // Sweep tracker: cycle n=1 is the cycle right after start is accepted.
  initial begin
    for (int i = 0; i < 2; i++) begin
      insw[i] = 0; ncyc[i] = 0;
      h_sig[i] = 0; h_cnt[i] = 0; h_max[i] = 0; h_cod[i] = 0; h_din[i] = 0;
    end
    forever begin
      @(posedge clk or posedge rst);
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          insw[i] = 0; ncyc[i] = 0;
          h_sig[i] = 0; h_cnt[i] = 0; h_max[i] = 0; h_cod[i] = 0; h_din[i] = 0;
        end else if (insw[i]) begin
          ncyc[i]++;
          if (ncyc[i] > NC * (settle_of(i) + 1) + 1) begin
            insw[i]  = 0;
            h_sig[i] = psig[i][NC]; h_cnt[i] = pcnt[i][NC];
            h_max[i] = pmax[i][NC]; h_cod[i] = pcod[i][NC];
            h_din[i] = NC - 1;
          end
        end else if (start) begin
          build(i);
          insw[i] = 1; ncyc[i] = 1;
        end
      end
    end
  end

  // Per-cycle compare of every output against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        string p;
        int s, l, m;
        logic [31:0] eb, ed, ein, es, ec, em, emc;
        p = (i == 0) ? "a" : "b";
        s = settle_of(i);
        l = NC * (s + 1);
        if (insw[i]) begin
          m = (ncyc[i] - 1) / (s + 1);
          if (m > NC) m = NC;
          eb  = (ncyc[i] <= l) ? 1 : 0;
          ed  = (ncyc[i] == l + 1) ? 1 : 0;
          ein = (m > NC - 1) ? NC - 1 : m;
          es = psig[i][m]; ec = pcnt[i][m]; em = pmax[i][m]; emc = pcod[i][m];
        end else begin
          eb = 0; ed = 0; ein = h_din[i];
          es = h_sig[i]; ec = h_cnt[i]; em = h_max[i]; emc = h_cod[i];
        end
        chk({p, ".busy"},   32'(busy[i]), eb);
        chk({p, ".done"},   32'(done[i]), ed);
        chk({p, ".dut_in"}, 32'(din[i]),  ein);
        chk({p, ".sig"},    32'(sig[i]),  es);
        chk({p, ".nz"},     32'(nz[i]),   ec);
        chk({p, ".max"},    32'(mx[i]),   em);
        chk({p, ".mcode"},  32'(mc[i]),   emc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic lit(input string tag, input logic [23:0] es, input int ec,
                     input logic [23:0] em, input int emc);
    for (int i = 0; i < 2; i++) begin
      string p;
      p = (i == 0) ? {tag, ".a"} : {tag, ".b"};
      chk({p, ".sig"},   32'(sig[i]), 32'(es));
      chk({p, ".nz"},    32'(nz[i]),  ec);
      chk({p, ".max"},   32'(mx[i]),  32'(em));
      chk({p, ".mcode"}, 32'(mc[i]),  emc);
    end
  endtask

  task automatic lit_zero(input string tag);
    lit(tag, 24'h0, 0, 24'h0, 0);
    for (int i = 0; i < 2; i++) begin
      chk({tag, (i == 0) ? ".a" : ".b", ".busy"},   32'(busy[i]), 0);
      chk({tag, (i == 0) ? ".a" : ".b", ".done"},   32'(done[i]), 0);
      chk({tag, (i == 0) ? ".a" : ".b", ".dut_in"}, 32'(din[i]),  0);
    end
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while ((insw[0] || insw[1] || busy[0] || busy[1] || done[0] || done[1]) && c < 400) begin
      @(negedge clk);
      c++;
    end
    if (c >= 400) begin
      checks++;
      failures++;
      $display("FAIL wait_idle: still busy after %0d cycles, required idle", c);
    end
    @(negedge clk);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic set_identity();
    for (int k = 0; k < NC; k++) lut[k] = OUT_W'(k);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int ca, cb;
    rst = 1'b0;
    start = 1'b0;
    set_identity();
    #2 rst = 1'b1;
    #1 lit_zero("reset");
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    // Identity response, both settle times, with done-cycle measurement.
    set_identity();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    ca = 0; cb = 0;
    for (int c = 1; c <= 200 && (ca == 0 || cb == 0); c++) begin
      @(negedge clk);
      if (done[0] && ca == 0) ca = c;
      if (done[1] && cb == 0) cb = c;
    end
    chk("a.done_cycle", 32'(ca), 33);
    chk("b.done_cycle", 32'(cb), 65);
    wait_idle();
    lit("identity", 24'h0008F7, 15, 24'h00000F, 15);
    chk("identity.a.dut_in_held", 32'(din[0]), 15);

    // Constant all-ones response: even XOR count, no wrap, tie keeps code 0.
    for (int k = 0; k < NC; k++) lut[k] = 24'hFFFFFF;
    pulse_start();
    wait_idle();
    lit("allones", 24'h000000, 16, 24'hFFFFFF, 0);

    // Single MSB at code 0: exercises the rotate wrap.
    for (int k = 0; k < NC; k++) lut[k] = 24'h0;
    lut[0] = 24'h800000;
    pulse_start();
    wait_idle();
    lit("msb", 24'h004000, 1, 24'h800000, 0);

    // Randomised tables with zeros and repeated maxima.
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < NC; k++) begin
        case ($urandom_range(0, 3))
          0: lut[k] = 24'h0;
          1: lut[k] = 24'hABCDEF;
          2: lut[k] = OUT_W'($urandom);
          default: lut[k] = OUT_W'($urandom_range(1, 255));
        endcase
      end
      pulse_start();
      wait_idle();
    end

    // Extra start pulse mid-sweep must be ignored.
    set_identity();
    pulse_start();
    repeat (8) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_idle();
    lit("extra_pulse", 24'h0008F7, 15, 24'h00000F, 15);

    // Start held high: one sweep, then a restart in the first IDLE cycle.
    @(posedge clk); #1 start = 1'b1;
    for (int c = 0; c < 100 && !done[0]; c++) @(negedge clk);
    chk("hold.a.done_seen", 32'(done[0]), 1);
    @(posedge clk);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("hold.a.restart_busy", 32'(busy[0]), 1);
    wait_idle();
    lit("hold", 24'h0008F7, 15, 24'h00000F, 15);

    // Asynchronous reset in the middle of cycle 10 of a sweep.
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #3 rst = 1'b1;
    #1 lit_zero("midreset");
    @(negedge clk);
    #1 rst = 1'b0;
    wait_idle();
    pulse_start();
    wait_idle();
    lit("after_reset", 24'h0008F7, 15, 24'h00000F, 15);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
